// File: rtl/bram_fifo_ctrl.sv
// First-word-fall-through FIFO controller driving both ports of a dual-port block RAM.
// A 2-entry skid buffer absorbs the RAM's 1-cycle read latency to sustain one word per cycle.
module bram_fifo_ctrl #(
    parameter int ADDR_W = 13,
    parameter int DATA_W = 2
) (
    input  logic              clk,
    input  logic              rstn,
    input  logic              clr,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic [ADDR_W:0]   count,
    output logic [ADDR_W-1:0] A0,
    output logic [DATA_W-1:0] D0,
    output logic              WE0,
    output logic [DATA_W-1:0] WEM0,
    output logic              CE0,
    output logic [ADDR_W-1:0] A1,
    output logic [DATA_W-1:0] D1,
    output logic              WE1,
    output logic [DATA_W-1:0] WEM1,
    output logic              CE1,
    input  logic [DATA_W-1:0] Q1
);

    localparam logic [ADDR_W:0] DEPTH_C = {1'b1, {ADDR_W{1'b0}}};

    logic [ADDR_W-1:0] wptr_q, wptr_d;
    logic [ADDR_W-1:0] rptr_q, rptr_d;
    logic [ADDR_W:0]   ram_cnt_q, ram_cnt_d;
    logic              inflight_q, inflight_d;
    logic [DATA_W-1:0] buf0_q, buf0_d;
    logic [DATA_W-1:0] buf1_q, buf1_d;
    logic [1:0]        buf_cnt_q, buf_cnt_d;
    logic [ADDR_W:0]   count_q, count_d;

    logic       push;
    logic       pop;
    logic       issue;
    logic [2:0] occ_after_pop;

    assign in_ready  = (ram_cnt_q != DEPTH_C) & ~clr;
    // Write strobes are held off while rstn is low so the RAM port is idle during reset.
    assign push      = in_valid & in_ready & rstn;
    assign out_valid = (buf_cnt_q != 2'd0) & ~clr;
    assign out_data  = buf0_q;
    assign pop       = out_valid & out_ready;

    assign occ_after_pop = {1'b0, buf_cnt_q} + {2'b00, inflight_q} - {2'b00, pop};
    assign issue         = (ram_cnt_q != '0) & ~clr & (occ_after_pop < 3'd2);

    assign CE0  = push;
    assign WE0  = push;
    assign WEM0 = {DATA_W{push}};
    assign A0   = wptr_q;
    assign D0   = in_data;

    assign CE1  = issue;
    assign A1   = rptr_q;
    assign WE1  = 1'b0;
    assign WEM1 = '0;
    assign D1   = '0;

    assign count = count_q;

    always_comb begin
        wptr_d     = wptr_q + ADDR_W'(push);
        rptr_d     = rptr_q + ADDR_W'(issue);
        inflight_d = issue;
        ram_cnt_d  = ram_cnt_q;
        if (push && !issue) begin
            ram_cnt_d = ram_cnt_q + 1'b1;
        end else if (issue && !push) begin
            ram_cnt_d = ram_cnt_q - 1'b1;
        end

        buf0_d    = buf0_q;
        buf1_d    = buf1_q;
        buf_cnt_d = buf_cnt_q;
        if (pop) begin
            buf0_d    = buf1_q;
            buf_cnt_d = buf_cnt_q - 2'd1;
        end
        // Returning read word lands behind whatever survives this cycle's pop.
        if (inflight_q && !clr) begin
            if (buf_cnt_d == 2'd0) begin
                buf0_d = Q1;
            end else begin
                buf1_d = Q1;
            end
            buf_cnt_d = buf_cnt_d + 2'd1;
        end

        if (clr) begin
            wptr_d     = '0;
            rptr_d     = '0;
            ram_cnt_d  = '0;
            inflight_d = 1'b0;
            buf_cnt_d  = '0;
        end

        count_d = ram_cnt_d + (ADDR_W+1)'(inflight_d) + (ADDR_W+1)'(buf_cnt_d);
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            wptr_q     <= '0;
            rptr_q     <= '0;
            ram_cnt_q  <= '0;
            inflight_q <= 1'b0;
            buf0_q     <= '0;
            buf1_q     <= '0;
            buf_cnt_q  <= '0;
            count_q    <= '0;
        end else begin
            wptr_q     <= wptr_d;
            rptr_q     <= rptr_d;
            ram_cnt_q  <= ram_cnt_d;
            inflight_q <= inflight_d;
            buf0_q     <= buf0_d;
            buf1_q     <= buf1_d;
            buf_cnt_q  <= buf_cnt_d;
            count_q    <= count_d;
        end
    end

endmodule

// File: tb/tb_bram_fifo_ctrl.sv
// Directed bench for bram_fifo_ctrl with a behavioural 8192x2 RAM and an in-order scoreboard.
module tb_bram_fifo_ctrl;

    localparam int ADDR_W = 13;
    localparam int DATA_W = 2;
    localparam int DEPTH  = 8192;

    logic              clk = 1'b0;
    logic              rstn;
    logic              clr;
    logic              in_valid;
    logic              in_ready;
    logic [DATA_W-1:0] in_data;
    logic              out_valid;
    logic              out_ready;
    logic [DATA_W-1:0] out_data;
    logic [ADDR_W:0]   count;
    logic [ADDR_W-1:0] A0, A1;
    logic [DATA_W-1:0] D0, D1, WEM0, WEM1, Q1;
    logic              WE0, WE1, CE0, CE1;

    logic [DATA_W-1:0] mem [0:DEPTH-1];

    int n_checks = 0;
    int n_pass   = 0;

    logic [DATA_W-1:0] sb[$];
    int data_err;

    bram_fifo_ctrl #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
        .clk(clk), .rstn(rstn), .clr(clr),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .count(count),
        .A0(A0), .D0(D0), .WE0(WE0), .WEM0(WEM0), .CE0(CE0),
        .A1(A1), .D1(D1), .WE1(WE1), .WEM1(WEM1), .CE1(CE1),
        .Q1(Q1)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (CE0 && WE0) mem[A0] <= (mem[A0] & ~WEM0) | (D0 & WEM0);
        if (CE1) Q1 <= mem[A1];
    end

    task automatic check(input string tag, input int obs, input int exp);
        n_checks++;
        if (obs == exp) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    // Call right after a negedge: logs accepted inputs and compares popped words.
    task automatic sb_update();
        logic [DATA_W-1:0] w;
        if (in_valid && in_ready) sb.push_back(in_data);
        if (out_valid && out_ready) begin
            if (sb.size() == 0) data_err++;
            else begin
                w = sb.pop_front();
                if (w != out_data) data_err++;
            end
        end
    endtask

    initial begin
        int accepts, errs, bubbles, cnt_err, ce1_err, occ_err, ram_m;
        bit wrap_a0, wrap_a1, full;
        int last_a0, last_a1;

        rstn = 1'b0; clr = 1'b0; in_valid = 1'b0; out_ready = 1'b0; in_data = '0;
        Q1 = '0;

        // Reset with random stream inputs
        for (int i = 0; i < 3; i++) begin
            in_valid  = 1'($urandom_range(0, 1));
            out_ready = 1'($urandom_range(0, 1));
            in_data   = 2'($urandom_range(0, 3));
            @(negedge clk);
            check("rst_in_ready", in_ready, 1);
            check("rst_out_valid", out_valid, 0);
            check("rst_count", count, 0);
            check("rst_ce0", CE0, 0);
            check("rst_ce1", CE1, 0);
        end
        next_cycle();
        rstn = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
        @(negedge clk);
        check("idle_in_ready", in_ready, 1);
        check("idle_out_valid", out_valid, 0);
        check("idle_count", count, 0);
        check("idle_port1", {WE1, WEM1, D1}, 0);

        // Single word latency: push at t, visible at t+3
        next_cycle();
        in_valid = 1'b1; in_data = 2'b10; out_ready = 1'b1;
        @(negedge clk);
        check("sw_ce0", CE0, 1);
        check("sw_a0", A0, 0);
        check("sw_wem0", WEM0, 3);
        next_cycle();
        in_valid = 1'b0;
        @(negedge clk);
        check("sw_t1_ce1", CE1, 1);
        check("sw_t1_a1", A1, 0);
        check("sw_t1_count", count, 1);
        check("sw_t1_ov", out_valid, 0);
        next_cycle();
        @(negedge clk);
        check("sw_t2_ov", out_valid, 0);
        next_cycle();
        @(negedge clk);
        check("sw_t3_ov", out_valid, 1);
        check("sw_t3_data", out_data, 2);
        next_cycle();
        @(negedge clk);
        check("sw_t4_ov", out_valid, 0);
        check("sw_t4_count", count, 0);

        // Fill to capacity with out_ready low
        next_cycle();
        out_ready = 1'b0;
        accepts = 0; wrap_a0 = 1'b0; last_a0 = -1; full = 1'b0;
        for (int c = 0; c < 9000 && !full; c++) begin
            in_valid = 1'b1;
            in_data  = 2'(accepts % 4);
            @(negedge clk);
            if (in_ready) begin
                if (CE0 && A0 == 0 && last_a0 == DEPTH - 1) wrap_a0 = 1'b1;
                if (CE0) last_a0 = int'(A0);
                accepts++;
                next_cycle();
            end else begin
                full = 1'b1;
            end
        end
        in_valid = 1'b0;
        check("fill_accepts", accepts, DEPTH + 2);
        check("fill_count", count, DEPTH + 2);
        check("fill_a0_wrap", wrap_a0, 1);
        check("fill_head_valid", out_valid, 1);
        check("fill_head_data", out_data, 0);

        // Drain: one word per cycle, in order
        next_cycle();
        out_ready = 1'b1;
        errs = 0; wrap_a1 = 1'b0; last_a1 = -1;
        for (int i = 0; i < DEPTH + 2; i++) begin
            @(negedge clk);
            if (!out_valid || out_data != 2'(i % 4)) errs++;
            if (CE1 && A1 == 0 && last_a1 == DEPTH - 1) wrap_a1 = 1'b1;
            if (CE1) last_a1 = int'(A1);
            next_cycle();
        end
        @(negedge clk);
        check("drain_errs", errs, 0);
        check("drain_a1_wrap", wrap_a1, 1);
        check("drain_out_valid", out_valid, 0);
        check("drain_count", count, 0);
        check("drain_in_ready", in_ready, 1);

        // Streaming: continuous push and pop
        next_cycle();
        data_err = 0; bubbles = 0; cnt_err = 0;
        in_valid = 1'b1; out_ready = 1'b1;
        for (int c = 0; c < 20000; c++) begin
            in_data = 2'($urandom_range(0, 3));
            @(negedge clk);
            if (c >= 3 && !out_valid) bubbles++;
            if (c >= 3 && count != 14'd3) cnt_err++;
            sb_update();
            next_cycle();
        end
        in_valid = 1'b0;
        for (int c = 0; c < 20 && sb.size() != 0; c++) begin
            @(negedge clk);
            sb_update();
            next_cycle();
        end
        @(negedge clk);
        check("stream_bubbles", bubbles, 0);
        check("stream_count_err", cnt_err, 0);
        check("stream_data_err", data_err, 0);
        check("stream_left", sb.size(), 0);
        check("stream_end_count", count, 0);

        // Random back-pressure
        next_cycle();
        data_err = 0; ce1_err = 0; occ_err = 0; cnt_err = 0; ram_m = 0;
        for (int c = 0; c < 4000; c++) begin
            in_valid  = 1'($urandom_range(0, 1));
            out_ready = 1'($urandom_range(0, 1));
            in_data   = 2'($urandom_range(0, 3));
            @(negedge clk);
            if (CE1 && ram_m == 0) ce1_err++;
            if (int'(count) != sb.size()) cnt_err++;
            if (int'(count) - ram_m > 2 || int'(count) < ram_m) occ_err++;
            ram_m = ram_m + ((in_valid && in_ready) ? 1 : 0) - (CE1 ? 1 : 0);
            sb_update();
            next_cycle();
        end
        in_valid = 1'b0; out_ready = 1'b1;
        for (int c = 0; c < 6000 && sb.size() != 0; c++) begin
            @(negedge clk);
            sb_update();
            next_cycle();
        end
        @(negedge clk);
        check("rand_data_err", data_err, 0);
        check("rand_ce1_empty", ce1_err, 0);
        check("rand_count_err", cnt_err, 0);
        check("rand_occupancy", occ_err, 0);
        check("rand_left", sb.size(), 0);
        check("rand_end_valid", out_valid, 0);

        // Flush while a read is in flight
        next_cycle();
        out_ready = 1'b1; in_valid = 1'b1; in_data = 2'b11;
        next_cycle();
        in_data = 2'b10;
        @(negedge clk);
        check("flush_issue", CE1, 1);
        next_cycle();
        clr = 1'b1; in_valid = 1'b1; in_data = 2'b01;
        @(negedge clk);
        check("flush_ov", out_valid, 0);
        check("flush_in_ready", in_ready, 0);
        check("flush_ce0", CE0, 0);
        check("flush_ce1", CE1, 0);
        next_cycle();
        clr = 1'b0; in_valid = 1'b0;
        @(negedge clk);
        check("flush_count", count, 0);
        check("flush_ov_after", out_valid, 0);
        errs = 0;
        for (int c = 0; c < 5; c++) begin
            next_cycle();
            @(negedge clk);
            if (out_valid || count != 0) errs++;
        end
        check("flush_stale", errs, 0);
        next_cycle();
        in_valid = 1'b1; in_data = 2'b01;
        next_cycle();
        in_valid = 1'b0;
        next_cycle();
        next_cycle();
        @(negedge clk);
        check("flush_new_valid", out_valid, 1);
        check("flush_new_data", out_data, 1);
        next_cycle();

        // Asynchronous reset mid-burst
        out_ready = 1'b0; in_valid = 1'b1;
        for (int c = 0; c < 6; c++) begin
            in_data = 2'(c % 4);
            next_cycle();
        end
        in_valid = 1'b0;
        #2 rstn = 1'b0;
        #1;
        check("arst_count", count, 0);
        check("arst_ov", out_valid, 0);
        next_cycle();
        rstn = 1'b1;
        errs = 0;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            if (out_valid || count != 0 || CE1) errs++;
            next_cycle();
        end
        check("arst_stale", errs, 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
